// File: rtl/nios2_debug_mon_access.sv
// Debug monitor memory-access engine: turns JTAG debug-slave ocimem strobes
// into single-word reads/writes on the monitor RAM port, with ack timeout.
module nios2_debug_mon_access #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic              ram_rd,
  output logic              ram_wr,
  input  logic [31:0]       ram_rdata,
  input  logic              ram_ack,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    WR    = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] ram_addr_d, mon_a_d;
  logic [31:0]       ram_wdata_d, mon_d_d;
  logic              ram_rd_d, ram_wr_d, ready_d, error_d;
  logic              err_set, err_clr, any_strobe, last_wait;
  logic [ADDR_W-1:0] jdo_addr, addr_inc;

  // Bits of jdo outside the command fields carry no meaning here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign jdo_addr   = jdo[ADDR_W+24:25];
  assign addr_inc   = ADDR_W'(MonAReg + ADDR_W'(1));
  assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign last_wait  = (CNT_W'(cnt + CNT_W'(1)) == TIMEOUT_C);

  // Next-state and next-value logic for every registered output.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    ram_addr_d  = ram_addr;
    ram_wdata_d = ram_wdata;
    ram_rd_d    = ram_rd;
    ram_wr_d    = ram_wr;
    mon_a_d     = MonAReg;
    mon_d_d     = MonDReg;
    ready_d     = monitor_ready;
    err_set     = 1'b0;
    err_clr     = 1'b0;

    unique case (state)
      IDLE: begin
        if (take_action_ocimem_b) begin
          mon_d_d     = jdo[34:3];
          ram_wdata_d = jdo[34:3];
          ram_addr_d  = MonAReg;
          ram_wr_d    = 1'b1;
          ready_d     = 1'b0;
          cnt_d       = '0;
          state_d     = WR;
        end else if (take_action_ocimem_a) begin
          mon_a_d = jdo_addr;
          err_clr = 1'b1;
          if (jdo[35]) begin
            ram_addr_d = jdo_addr;
            ram_rd_d   = 1'b1;
            ready_d    = 1'b0;
            cnt_d      = '0;
            state_d    = RD;
          end
        end else if (take_no_action_ocimem_a && jdo[35]) begin
          ram_addr_d = MonAReg;
          ram_rd_d   = 1'b1;
          ready_d    = 1'b0;
          cnt_d      = '0;
          state_d    = RD;
        end
      end

      RD, WR: begin
        err_set = any_strobe;
        if (ram_ack) begin
          if (state == RD) mon_d_d = ram_rdata;
          mon_a_d  = addr_inc;
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          ready_d  = 1'b1;
          state_d  = IDLE;
        end else if (last_wait) begin
          ram_rd_d = 1'b0;
          ram_wr_d = 1'b0;
          state_d  = ABORT;
        end else begin
          cnt_d = CNT_W'(cnt + CNT_W'(1));
        end
      end

      ABORT: begin
        err_set = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // A same-cycle set takes precedence over the clear.
  assign error_d = err_set | (monitor_error & ~err_clr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      ram_addr      <= '0;
      ram_wdata     <= '0;
      ram_rd        <= 1'b0;
      ram_wr        <= 1'b0;
      MonAReg       <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      ram_addr      <= ram_addr_d;
      ram_wdata     <= ram_wdata_d;
      ram_rd        <= ram_rd_d;
      ram_wr        <= ram_wr_d;
      MonAReg       <= mon_a_d;
      MonDReg       <= mon_d_d;
      monitor_ready <= ready_d;
      monitor_error <= error_d;
    end
  end

endmodule

// File: tb/tb_nios2_debug_mon_access.sv
// Self-checking bench for nios2_debug_mon_access: directed table, corner
// sequences and random commands checked against a transaction-level model.
module tb_nios2_debug_mon_access;

  localparam int unsigned AW  = 9;
  localparam int unsigned TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic          ram_rd, ram_wr;
  logic [31:0]   ram_rdata;
  logic          ram_ack;
  logic [31:0]   MonDReg;
  logic [AW-1:0] MonAReg;
  logic          monitor_ready, monitor_error;

  nios2_debug_mon_access #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .MonDReg(MonDReg), .MonAReg(MonAReg),
    .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level reference state
  logic [AW-1:0] m_a;
  logic [31:0]   m_d;
  logic          m_err;

  typedef struct {
    int            kind;   // 0 = no_action_a, 1 = action_a, 2 = action_b
    logic [AW-1:0] addr;
    bit            rflag;
    logic [31:0]   wd;
    int            lat;    // ack in this request cycle (1-based); > TMO means none
    logic [31:0]   rdv;
    logic [2:0]    extra;  // extra lower-priority strobes {b,a,na}
    logic [AW-1:0] exp_a;
    logic [31:0]   exp_d;
    bit            exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_strobes(input logic [2:0] s);
    {take_action_ocimem_b, take_action_ocimem_a, take_no_action_ocimem_a} = s;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_rd"}, 32'(ram_rd), 32'd0);
    chk({tag, "_wr"}, 32'(ram_wr), 32'd0);
    chk({tag, "_ready"}, 32'(monitor_ready), 32'd1);
    chk({tag, "_areg"}, 32'(MonAReg), 32'(m_a));
    chk({tag, "_dreg"}, MonDReg, m_d);
    chk({tag, "_err"}, 32'(monitor_error), 32'(m_err));
  endtask

  // Issue one command at a negedge and follow it to completion.
  task automatic run_op(input int kind, input logic [AW-1:0] addr, input bit rflag,
                        input logic [31:0] wd, input int lat, input logic [31:0] rdv,
                        input logic [2:0] extra);
    logic [37:0] j;
    bit          is_wr, active, hit;
    int          held;
    j = {6'($urandom), $urandom};
    if (kind == 2) j[34:3] = wd;
    else           j[33:25] = addr;
    j[35] = rflag;
    jdo = j;
    set_strobes(extra | 3'(3'b001 << kind));
    @(negedge clk);
    set_strobes(3'b000);
    is_wr  = (kind == 2);
    active = is_wr || rflag;
    if (kind == 1) begin m_a = addr; m_err = 1'b0; end
    if (is_wr) m_d = wd;
    if (active) begin
      held = (lat <= int'(TMO)) ? lat : int'(TMO);
      for (int c = 0; c < held; c++) begin
        chk("req", 32'(is_wr ? ram_wr : ram_rd), 32'd1);
        chk("other_req", 32'(is_wr ? ram_rd : ram_wr), 32'd0);
        chk("req_addr", 32'(ram_addr), 32'(m_a));
        if (is_wr) chk("wdata", ram_wdata, m_d);
        chk("busy_ready", 32'(monitor_ready), 32'd0);
        chk("busy_err", 32'(monitor_error), 32'(m_err));
        hit = (c == lat - 1);
        ram_ack   = hit;
        ram_rdata = hit ? rdv : $urandom;
        @(negedge clk);
        ram_ack   = 1'b0;
        ram_rdata = $urandom;
      end
      if (lat <= int'(TMO)) begin
        if (!is_wr) m_d = rdv;
        m_a = AW'(m_a + 1);
      end else begin
        chk("abort_rd", 32'(ram_rd), 32'd0);
        chk("abort_wr", 32'(ram_wr), 32'd0);
        chk("abort_ready", 32'(monitor_ready), 32'd0);
        chk("abort_areg", 32'(MonAReg), 32'(m_a));
        chk("abort_dreg", MonDReg, m_d);
        @(negedge clk);
        m_err = 1'b1;
      end
    end
    chk_idle("done");
  endtask

  initial begin
    tbl[0]  = '{1, 9'h010, 1'b1, 32'h0,        3, 32'hDEADBEEF, 3'b000, 9'h011, 32'hDEADBEEF, 1'b0};
    tbl[1]  = '{2, 9'h000, 1'b0, 32'h12345678, 1, 32'h0,        3'b000, 9'h012, 32'h12345678, 1'b0};
    tbl[2]  = '{1, 9'h1FF, 1'b0, 32'h0,        1, 32'h0,        3'b000, 9'h1FF, 32'h12345678, 1'b0};
    tbl[3]  = '{0, 9'h000, 1'b1, 32'h0,        2, 32'hA5A50001, 3'b000, 9'h000, 32'hA5A50001, 1'b0};
    tbl[4]  = '{0, 9'h000, 1'b1, 32'h0,        1, 32'h00001234, 3'b000, 9'h001, 32'h00001234, 1'b0};
    tbl[5]  = '{0, 9'h000, 1'b0, 32'h0,        1, 32'h0,        3'b000, 9'h001, 32'h00001234, 1'b0};
    tbl[6]  = '{0, 9'h000, 1'b1, 32'h0,        9, 32'hFFFF0000, 3'b000, 9'h001, 32'h00001234, 1'b1};
    tbl[7]  = '{1, 9'h0AA, 1'b0, 32'h0,        1, 32'h0,        3'b000, 9'h0AA, 32'h00001234, 1'b0};
    tbl[8]  = '{2, 9'h000, 1'b0, 32'hCAFEF00D, 9, 32'h0,        3'b000, 9'h0AA, 32'hCAFEF00D, 1'b1};
    tbl[9]  = '{2, 9'h000, 1'b0, 32'h600DF00D, 1, 32'h0,        3'b011, 9'h0AB, 32'h600DF00D, 1'b1};
    tbl[10] = '{1, 9'h155, 1'b1, 32'h0,        4, 32'h0BADC0DE, 3'b000, 9'h156, 32'h0BADC0DE, 1'b0};
    tbl[11] = '{2, 9'h000, 1'b0, 32'hFFFFFFFF, 2, 32'h0,        3'b001, 9'h157, 32'hFFFFFFFF, 1'b0};

    reset = 1'b1;
    jdo = '0;
    set_strobes(3'b000);
    ram_ack = 1'b0;
    ram_rdata = '0;
    m_a = '0; m_d = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", ram_wdata, 32'd0);
    chk_idle("rst");
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].kind, tbl[i].addr, tbl[i].rflag, tbl[i].wd, tbl[i].lat, tbl[i].rdv, tbl[i].extra);
      chk("tbl_areg", 32'(MonAReg), 32'(tbl[i].exp_a));
      chk("tbl_dreg", MonDReg, tbl[i].exp_d);
      chk("tbl_err", 32'(monitor_error), 32'(tbl[i].exp_err));
    end

    // Write strobe while a read waits: read finishes, no write, error set
    jdo = '0;
    jdo[33:25] = 9'h0C3;
    jdo[35] = 1'b1;
    set_strobes(3'b010);
    @(negedge clk);
    set_strobes(3'b000);
    m_a = 9'h0C3; m_err = 1'b0;
    chk("busy_rd", 32'(ram_rd), 32'd1);
    chk("busy_addr", 32'(ram_addr), 32'h0C3);
    jdo[34:3] = 32'h11112222;
    set_strobes(3'b100);
    @(negedge clk);
    set_strobes(3'b000);
    chk("busy_rd2", 32'(ram_rd), 32'd1);
    chk("busy_nowr", 32'(ram_wr), 32'd0);
    chk("busy_errset", 32'(monitor_error), 32'd1);
    ram_ack = 1'b1;
    ram_rdata = 32'h5EED5EED;
    @(negedge clk);
    ram_ack = 1'b0;
    m_a = 9'h0C4; m_d = 32'h5EED5EED; m_err = 1'b1;
    chk_idle("busy_done");

    // Reset during a write, then a stale ack
    jdo = '0;
    jdo[34:3] = 32'h77778888;
    set_strobes(3'b100);
    @(negedge clk);
    set_strobes(3'b000);
    chk("rw_wr1", 32'(ram_wr), 32'd1);
    @(negedge clk);
    chk("rw_wr2", 32'(ram_wr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_a = '0; m_d = '0; m_err = 1'b0;
    chk_idle("rw_rst");
    ram_ack = 1'b1;
    ram_rdata = 32'hBADBAD00;
    @(negedge clk);
    ram_ack = 1'b0;
    chk_idle("rw_late_ack");

    // Random commands against the model
    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 2));
      run_op(k, AW'($urandom), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(1, 6)), $urandom,
             3'($urandom) & 3'((1 << k) - 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_debug_mon_access.md
# nios2_debug_mon_access

Debug monitor memory-access engine for the Nios II JTAG debug slave. It sits directly downstream of the debug slave's system-clock stage. It consumes the `jdo` word and the `take_action_ocimem_*` strobes and turns them into word reads and writes on the on-chip debug monitor RAM port. It returns read data as `MonDReg` to the TCK-side shift logic and reports `monitor_ready` / `monitor_error`.

## Interface
Parameters:
- `ADDR_W`, default 9: monitor RAM word-address width (byte address bits [ADDR_W+1:2]).
- `TIMEOUT`, default 255: maximum cycles to wait for `ram_ack` before aborting; range 1..255.

Ports (clock and reset first):
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `jdo`  in  38  JTAG data word, stable whenever a strobe is high.
- `take_action_ocimem_a`  in  1  one-cycle strobe: load address; optional read.
- `take_no_action_ocimem_a`  in  1  one-cycle strobe: read-next.
- `take_action_ocimem_b`  in  1  one-cycle strobe: write data.
- `ram_addr`  out  ADDR_W  word address to monitor RAM.
- `ram_wdata`  out  32  write data.
- `ram_rd`  out  1  read request, held until ack.
- `ram_wr`  out  1  write request, held until ack.
- `ram_rdata`  in  32  read data, valid in the `ram_ack` cycle.
- `ram_ack`  in  1  request completion.
- `MonDReg`  out  32  monitor data register.
- `MonAReg`  out  ADDR_W  current word address.
- `monitor_ready`  out  1  engine idle and last operation complete.
- `monitor_error`  out  1  sticky error: timeout or command while busy.

## Operation
**Command decode.** Applies on the strobe cycle, in IDLE only.
- Priority when strobes coincide: `take_action_ocimem_b` > `take_action_ocimem_a` > `take_no_action_ocimem_a`. Lower-priority strobes are dropped silently.
- `take_action_ocimem_a`:
  - Loads `MonAReg <= jdo[ADDR_W+24:25]`.
  - Clears `monitor_error`.
  - If `jdo[35]`=1, starts a read at the new address; otherwise stays IDLE.
- `take_no_action_ocimem_a`: if `jdo[35]`=1, starts a read at `MonAReg`; else no effect.
- `take_action_ocimem_b`: loads `MonDReg <= jdo[34:3]` and starts a write of that value at `MonAReg`.

**States.** IDLE, RD, WR, ABORT.
- IDLE → RD / WR on an accepted command. `monitor_ready` drops and the timeout counter clears.
- RD:
  - `ram_rd`=1 and `ram_addr`=`MonAReg` are held.
  - On `ram_ack`: `MonDReg <= ram_rdata`, `MonAReg <= MonAReg+1`, → IDLE.
- WR:
  - `ram_wr`=1, `ram_addr`=`MonAReg` and `ram_wdata`=`MonDReg` are held.
  - On `ram_ack`: `MonAReg <= MonAReg+1`, → IDLE.
- RD/WR timeout: the counter increments each cycle without ack. When it equals TIMEOUT, → ABORT.
- ABORT (one cycle):
  - Requests are low; sets `monitor_error`; → IDLE.
  - `MonAReg` and `MonDReg` are unchanged.

**Other rules.**
- Address increment is modulo 2^ADDR_W: all-ones wraps to 0.
- A strobe arriving in RD, WR or ABORT is ignored. It sets `monitor_error` and does not disturb the in-flight operation.
- `ram_ack` is ignored in IDLE and ABORT.
- `monitor_error` clears only on reset or on an accepted `take_action_ocimem_a`. If the same cycle also sets it, the set wins.

## Timing
- **Reset values:**
  - State IDLE; `MonDReg`=0, `MonAReg`=0.
  - `ram_rd`=`ram_wr`=0, `ram_addr`=0, `ram_wdata`=0.
  - `monitor_ready`=1, `monitor_error`=0.
- Reset asserted mid-operation drops requests the next edge. A late `ram_ack` after reset is ignored.
- All outputs are registered.
- **Strobe to request.** Strobe at edge N → `ram_rd`/`ram_wr` high from cycle N+1.
- **Ack to completion.** `ram_ack` sampled at edge M (M ≥ N+1) → at M+1:
  - requests low;
  - `MonDReg` (reads) and `MonAReg` updated;
  - `monitor_ready`=1.
- Minimum strobe-to-ready latency: 2 cycles.
- **Timeout.** Without ack, requests are held for exactly TIMEOUT cycles, then one ABORT cycle. `monitor_ready`=1 and `monitor_error`=1 appear TIMEOUT+2 cycles after the strobe.
- Back-to-back: a new strobe is accepted in the first cycle `monitor_ready`=1.

## Test plan
- Reset, then `take_action_ocimem_a` with `jdo[33:25]`=0x010 and `jdo[35]`=1; RAM acks 3 cycles later with 0xDEADBEEF → `ram_addr`=0x010, `MonDReg`=0xDEADBEEF, `MonAReg`=0x011, `monitor_ready` back high at ack+1.
- `take_action_ocimem_b` with `jdo[34:3]`=0x12345678 at `MonAReg`=0x011, same-cycle-next ack → `ram_wr` high exactly 1 cycle, `ram_wdata`=0x12345678, `MonAReg`=0x012.
- Set address 0x1FF, then issue two `take_no_action_ocimem_a` reads with `jdo[35]`=1 → `ram_addr` 0x1FF then 0x000; `MonAReg` ends at 0x001.
- TIMEOUT=4, read with no ack → `ram_rd` high 4 cycles, ABORT, `monitor_error`=1, `MonDReg` unchanged. A following address strobe clears `monitor_error`.
- `take_action_ocimem_b` strobed while a read is waiting → the read completes normally, no write is issued, `monitor_error`=1.
- Assert `reset` while in WR → next cycle `ram_wr`=0, `MonAReg`=0, `monitor_ready`=1; an ack one cycle later causes no change.
